// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive data path.
//   - PARITY_BITS : 1 when RX_PARITY_EN is defined, otherwise 0
//   - START_BIT / STOP_BIT : required line levels of the framing bits
//   - rx_state_e  : deserializer control states
//   - frame_w()   : total serial frame length for a given data width
// Configuration macro: RX_PARITY_EN (adds one even-parity bit after data).
// ---------------------------------------------------------------------------
package uart_rx_pkg;

`ifdef RX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        HOLD    = 2'd2
    } rx_state_e;

    // One start bit, the data bits, optional parity, one stop bit.
    function automatic int frame_w(input int data_w);
        return 1 + data_w + PARITY_BITS + 1;
    endfunction

endpackage : uart_rx_pkg

// File: rtl/rx_bit_counter.sv
// ---------------------------------------------------------------------------
// rx_bit_counter
// Saturating up-counter with synchronous clear, used to count received
// bit strobes of the current frame.
// Ports:
//   Clk    - rising-edge clock
//   Reset  - synchronous, active-high reset
//   clear  - restart counting (takes priority over a plain increment)
//   enable - count one bit this cycle
//   count  - current bit count, saturates at MAX
// ---------------------------------------------------------------------------
module rx_bit_counter #(
    parameter int MAX = 11,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            // A bit arriving on the clearing cycle is the first bit of the
            // next frame, so it must not be lost.
            count <= enable ? W'(1) : '0;
        end else if (enable && (count != W'(MAX))) begin
            count <= count + 1'b1;
        end
    end

endmodule : rx_bit_counter

// File: rtl/rx_deserializer.sv
// ---------------------------------------------------------------------------
// rx_deserializer
// Assembles LSB-first serial bits into a frame, checks framing (and parity
// when RX_PARITY_EN is defined) and presents the data byte in a holding
// register with a valid/ready handshake. The shift register keeps
// collecting the next frame while the previous one is held.
// Ports:
//   Clk          - rising-edge clock
//   Reset        - synchronous, active-high reset
//   Serial_In    - synchronized RX line, sampled on Shift_Show
//   Shift_Show   - one-cycle bit-sample strobe
//   Flag_Rx      - one-cycle frame-complete strobe
//   Data_Ready   - consumer accepts the held byte
//   Data_Out     - received data, valid while Data_Valid
//   Data_Valid   - held byte available
//   Frame_Error  - start/stop/bit-count error of the held byte
//   Parity_Error - parity mismatch of the held byte (0 without RX_PARITY_EN)
//   Overrun      - sticky: a frame was dropped while the holder was full
// Configuration macro: RX_PARITY_EN.
// ---------------------------------------------------------------------------
module rx_deserializer
    import uart_rx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Serial_In,
    input  logic              Shift_Show,
    input  logic              Flag_Rx,
    input  logic              Data_Ready,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Data_Valid,
    output logic              Frame_Error,
    output logic              Parity_Error,
    output logic              Overrun
);

    localparam int FRAME_W = frame_w(DATA_W);
    localparam int CNT_MAX = FRAME_W + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    rx_state_e          state;
    rx_state_e          next_state;
    logic [FRAME_W-1:0] shift_reg;
    logic [CNT_W-1:0]   bit_count;
    logic               in_check;
    logic               accept;
    logic               load;
    logic               frame_bad;
    logic               parity_bad;

    // ------------------------------------------------------------------
    // Bit collection: new bits enter at the MSB, so after FRAME_W strobes
    // the start bit sits in bit 0 and the stop bit in the MSB.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shift_reg <= '0;
        end else if (Shift_Show) begin
            shift_reg <= {Serial_In, shift_reg[FRAME_W-1:1]};
        end
    end

    rx_bit_counter #(
        .MAX (CNT_MAX),
        .W   (CNT_W)
    ) u_bit_counter (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (in_check),
        .enable (Shift_Show),
        .count  (bit_count)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            COLLECT: if (Flag_Rx) next_state = CHECK;
            // Flag_Rx is deliberately ignored here; the stray strobe shows
            // up as a short bit count on the following frame.
            CHECK:   next_state = HOLD;
            HOLD: begin
                if (Flag_Rx)     next_state = CHECK;
                else if (accept) next_state = COLLECT;
            end
            default: next_state = COLLECT;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame evaluation, performed on the registered frame during CHECK
    // (a bit shifted together with Flag_Rx is already included).
    // ------------------------------------------------------------------
    assign in_check  = (state == CHECK);
    assign accept    = Data_Valid && Data_Ready;
    // An empty holder, or one emptied on this very edge, may take the frame.
    assign load      = in_check && (!Data_Valid || Data_Ready);

    assign frame_bad = (bit_count != CNT_W'(FRAME_W))
                    || (shift_reg[0] != START_BIT)
                    || (shift_reg[FRAME_W-1] != STOP_BIT);

`ifdef RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero.
    assign parity_bad = ^shift_reg[DATA_W+1:1];
`else
    assign parity_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Holding register and handshake
    // ------------------------------------------------------------------
    // NOTE: the holding register is reset explicitly so no stale byte or
    // flag can appear after reset; it is a handful of flops, not a RAM.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Data_Out     <= '0;
            Data_Valid   <= 1'b0;
            Frame_Error  <= 1'b0;
            Parity_Error <= 1'b0;
        end else if (load) begin
            Data_Out     <= shift_reg[DATA_W:1];
            Data_Valid   <= 1'b1;
            Frame_Error  <= frame_bad;
            Parity_Error <= parity_bad;
        end else if (accept) begin
            Data_Valid   <= 1'b0;
        end
    end

    // Overrun is set by a dropped frame and cleared by the next handshake;
    // the two can never coincide because a drop requires no acceptance.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Overrun <= 1'b0;
        end else if (in_check && Data_Valid && !Data_Ready) begin
            Overrun <= 1'b1;
        end else if (accept) begin
            Overrun <= 1'b0;
        end
    end

endmodule : rx_deserializer

// File: doc/rx_deserializer.md
RX_DESERIALIZER -- requirements
Module: rx_deserializer

Interface
REQ-001 SHALL have parameter: DATA_W, 8, number of data bits per frame (5..9).
REQ-002 SHALL have port: Clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: Serial_In  input  1  synchronized RX line, sampled only on Shift_Show.
REQ-005 SHALL have port: Shift_Show  input  1  one-cycle bit-sample strobe from the RX control stage.
REQ-006 SHALL have port: Flag_Rx  input  1  one-cycle frame-complete strobe from the RX control stage.
REQ-007 SHALL have port: Data_Ready  input  1  consumer accepts the held byte.
REQ-008 SHALL have port: Data_Out  output  DATA_W  received byte, valid while Data_Valid.
REQ-009 SHALL have port: Data_Valid  output  1  held byte available.
REQ-010 SHALL have port: Frame_Error  output  1  start/stop/bit-count error, qualified by Data_Valid.
REQ-011 SHALL have port: Parity_Error  output  1  parity mismatch, qualified by Data_Valid.
REQ-012 SHALL have port: Overrun  output  1  sticky, frame dropped while holding register full.

Function
REQ-013 SHALL define FRAME_W = 1 start + DATA_W + parity bit (if enabled) + 1 stop.
REQ-014 SHALL, on Shift_Show, shift Serial_In into MSB of a FRAME_W shift register (LSB-first line order) and increment the bit counter, saturating at FRAME_W+1.
REQ-015 SHALL, when Shift_Show and Flag_Rx coincide, apply the shift first and evaluate the frame including that bit.
REQ-016 SHALL implement states COLLECT, CHECK, HOLD; Reset -> COLLECT.
REQ-017 SHALL go COLLECT->CHECK on Flag_Rx; CHECK lasts exactly one cycle, clears the bit counter, then goes to HOLD.
REQ-018 SHALL continue collecting the next frame's bits while in CHECK or HOLD (shift register is independent of the holding register).
REQ-019 SHALL, in CHECK, set Frame_Error if bit count != FRAME_W, start bit != 0, or stop bit != 1; frames with errors are still delivered.
REQ-020 SHALL assert Data_Valid the cycle after CHECK (latency: Flag_Rx at cycle N -> Data_Valid at N+2) and hold Data_Out/flags stable until accepted.
REQ-021 SHALL complete the handshake on Data_Valid && Data_Ready; Data_Valid deasserts next cycle unless a new frame loads that same cycle.
REQ-022 SHALL, when a frame reaches CHECK while Data_Valid is high and not accepted that cycle, discard the new frame, keep old data, and set Overrun.
REQ-023 SHALL load the new frame without Overrun when acceptance and CHECK coincide.
REQ-024 SHALL clear Overrun on the next successful handshake.
REQ-025 SHALL ignore Flag_Rx received while in CHECK (counted as Frame_Error on the following frame via bit count).

Reset
REQ-026 SHALL reset Data_Out=0, Data_Valid=0, Frame_Error=0, Parity_Error=0, Overrun=0, shift register=0, bit counter=0, state=COLLECT.
REQ-027 SHALL, on Reset mid-frame or mid-HOLD, drop all partial and held data with no output pulse.

Configuration
REQ-028 SHALL, with RX_PARITY_EN defined, include one even-parity bit after data; Parity_Error=1 when XOR(data,parity bit)=1.
REQ-029 SHALL, without RX_PARITY_EN, omit the parity bit from FRAME_W and tie Parity_Error to 0.

Structure
REQ-030 SHALL place FRAME_W computation, state enum, and START/STOP bit constants in package uart_rx_pkg.
REQ-031 SHALL use one sub-module rx_bit_counter (saturating counter with clear, enable).

Verification
REQ-032 SHALL test: DATA_W=8, no parity, bits 0,1,0,1,0,0,1,0,1,1 then Flag_Rx -> Data_Out=0xA5, Data_Valid at N+2, all error flags 0.
REQ-033 SHALL test: same frame with stop bit 0 -> Data_Out=0xA5, Frame_Error=1; 9 Shift_Show pulses only -> Frame_Error=1.
REQ-034 SHALL test: 0x3C held with Data_Ready=0, second frame 0x81 completes -> Data_Out stays 0x3C, Overrun=1; accept -> Overrun=0.
REQ-035 SHALL test: Data_Ready=1 in the CHECK cycle of frame 0x55 while 0x3C held -> 0x3C accepted, 0x55 valid next, Overrun=0.
REQ-036 SHALL test: RX_PARITY_EN, 0xA5 with parity bit 1 -> Parity_Error=1; parity bit 0 -> Parity_Error=0.
REQ-037 SHALL test: Reset after 5 bits then clean 0xA5 frame -> 0xA5 delivered, no error, no spurious Data_Valid.
